// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the bit-counter width helper.
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Wide enough to hold 0..WIDTH, although WIDTH itself is never observable.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_reg_universal_bit_counter.sv
// Counts shifts within a serial word, wraps at WIDTH and registers a
// one-cycle done pulse on every completed word.
module shift_bit_counter
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        inc,
  input  logic                        clr,
  output logic [cnt_width(WIDTH)-1:0] cnt,
  output logic                        done
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] r_cnt;
  logic          r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (inc) begin
      // The WIDTH-th shift wraps straight to zero so back-to-back words
      // produce a pulse every WIDTH cycles with no dead cycle.
      if (r_cnt == CW'(WIDTH - 1)) begin
        r_cnt  <= '0;
        r_done <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign cnt  = r_cnt;
  assign done = r_done;

endmodule

// File: rtl/shift_reg_universal.sv
// Universal shift register: hold, shift left, shift right and parallel load,
// with a word counter so it can act as a SIPO deserialiser or PISO serialiser.
module shift_reg_universal
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  mode,
  input  logic                        sdi,
  input  logic [WIDTH-1:0]            pdi,
  output logic [WIDTH-1:0]            q,
  output logic                        sdo,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt,
  output logic                        word_done
);

  logic [WIDTH-1:0] r_q;
  logic             w_shift;
  logic             w_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= RESET_VAL;
    end else begin
      case (mode)
        MODE_HOLD: r_q <= r_q;
        MODE_SHL:  r_q <= {r_q[WIDTH-2:0], sdi};
        MODE_SHR:  r_q <= {sdi, r_q[WIDTH-1:1]};
        MODE_LOAD: r_q <= pdi;
        default:   r_q <= r_q;
      endcase
    end
  end

  assign w_shift = (mode == MODE_SHL) || (mode == MODE_SHR);
  assign w_load  = (mode == MODE_LOAD);

  // word_done acts as a valid strobe for q: it is high for exactly the one
  // cycle in which q holds a complete word; there is no ready/backpressure.
  shift_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (w_shift),
    .clr  (w_load),
    .cnt  (bit_cnt),
    .done (word_done)
  );

  assign q   = r_q;
  assign sdo = (mode == MODE_SHR) ? r_q[0] : r_q[WIDTH-1];

endmodule
